reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: DATA_W, 32, register and data width in bits.
REQ-002 Parameter: BYPASS, 1, enables write-to-read forwarding when set to 1.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: rs1  input  5  read port 1 register index.
REQ-006 Port: rs2  input  5  read port 2 register index.
REQ-007 Port: read_data1  output  DATA_W  signed operand to ALU input a.
REQ-008 Port: read_data2  output  DATA_W  signed operand to ALU input b.
REQ-009 Port: RegWrite  input  1  write enable.
REQ-010 Port: rd  input  5  write register index.
REQ-011 Port: write_data  input  DATA_W  write value, normally the ALU result.
REQ-012 Port: dump_start  input  1  request to stream all 32 registers out.
REQ-013 Port: dump_valid  output  1  dump_data/dump_index are valid.
REQ-014 Port: dump_ready  input  1  sink accepts the current dump beat.
REQ-015 Port: dump_index  output  5  index of the register on dump_data.
REQ-016 Port: dump_data  output  DATA_W  registered value of register dump_index.
REQ-017 Port: dump_busy  output  1  high whenever the dump FSM is not IDLE.
REQ-018 Port: dump_done  output  1  single-cycle pulse after the last beat is accepted.

Function
REQ-019 Storage: 32 x DATA_W registers; x0 is not stored and always reads 0.
REQ-020 Reads are combinational: read_dataN = reg[rsN]; rsN=0 -> 0.
REQ-021 Write: at a rising edge with RegWrite=1 and rd!=0, reg[rd] <= write_data; rd=0 writes are discarded.
REQ-022 Bypass (BYPASS=1): if RegWrite=1, rd!=0 and rd==rsN, read_dataN = write_data in the same cycle; BYPASS=0 returns the old value.
REQ-023 Both read ports may address the same register; each independently obeys REQ-020 to REQ-022.
REQ-024 Dump FSM states: IDLE, STREAM, DONE.
REQ-025 IDLE: dump_valid=0, dump_busy=0, dump_done=0; dump_start=1 -> STREAM, dump_index<=0, dump_data<=0.
REQ-026 STREAM: dump_valid=1, dump_busy=1; dump_valid && dump_ready is a beat.
REQ-027 Beat with dump_index<31: dump_index<=dump_index+1, dump_data<=value of reg[dump_index+1].
REQ-028 Beat with dump_index=31: -> DONE; dump_valid drops the next cycle; dump_index holds at 31, with no wrap to 0.
REQ-029 No beat (dump_ready=0): dump_index and dump_data hold stable, and a write to that register does not change dump_data.
REQ-030 Load value: when dump_data loads at an edge, it takes write_data if the same edge writes that index (rd!=0), otherwise the array contents before the edge.
REQ-031 DONE: dump_done=1, dump_busy=1, dump_valid=0 for exactly one cycle, then -> IDLE.
REQ-032 dump_start is ignored in STREAM and DONE; a new dump is possible from IDLE the cycle after DONE.
REQ-033 Normal reads and writes continue unaffected during a dump; the dump never stalls the datapath.

Reset
REQ-034 With reset=1 at an edge, all registers x1..x31 <= 0 and the FSM <= IDLE.
REQ-035 With reset=1 at an edge, dump_index <= 0, dump_data <= 0, and dump_valid, dump_busy and dump_done are 0 the following cycle.
REQ-036 Reset takes priority over a write and over a dump beat in the same cycle.
REQ-037 Reset asserted mid-dump aborts the dump with no dump_done pulse.

Verification
REQ-038 Write/read: write x5=0xDEADBEEF; next cycle rs1=5 -> read_data1=0xDEADBEEF; write x0=0x1234 -> rs2=0 reads 0.
REQ-039 Bypass: RegWrite=1, rd=7, write_data=0xFFFFFFF9, rs1=rs2=7 in the same cycle -> both read 0xFFFFFFF9 (BYPASS=1), and the old value (BYPASS=0).
REQ-040 Full dump: load xi=i*3 and hold dump_ready=1 -> 32 consecutive beats, index 0..31, data 0,3,...,93, dump_done one cycle after beat 31.
REQ-041 Backpressure: toggle dump_ready 1-0-0-1 and write the currently held index mid-stall -> dump_data stays stable during the stall, with no skipped or duplicated index.
REQ-042 Reset mid-dump at index 12 -> next cycle dump_valid=0, dump_busy=0, no dump_done, all registers read 0.
REQ-043 dump_start pulsed during STREAM is ignored; dump_start the cycle after DONE starts a new dump at index 0.

Source files
------------

// File: rtl/reg_file.sv
// 32-entry register file with two combinational read ports, one write port,
// optional write-to-read forwarding and a valid/ready register dump stream.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic signed [DATA_W-1:0] read_data1,
  output logic signed [DATA_W-1:0] read_data2,
  input  logic                     RegWrite,
  input  logic [4:0]               rd,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     dump_start,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [4:0]               dump_index,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  localparam int NUM_RD = 2;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  logic [DATA_W-1:0] regs_q [1:31];
  logic              wr_en;

  assign wr_en = RegWrite && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= write_data;
    end
  end

  // Read ports
  logic [NUM_RD-1:0][4:0]        rs_idx;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  assign rs_idx = {rs2, rs1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    always_comb begin
      rdata[p] = '0;
      if (rs_idx[p] != 5'd0) begin
        if (BYPASS != 0 && wr_en && rd == rs_idx[p]) rdata[p] = write_data;
        else                                         rdata[p] = regs_q[rs_idx[p]];
      end
    end
  end

  assign read_data1 = rdata[0];
  assign read_data2 = rdata[1];

  // Dump stream
  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        nxt_idx;
  logic [DATA_W-1:0] nxt_val;

  assign nxt_idx = idx_q + 5'd1;

  // The next beat must see a write landing on the same edge it loads.
  always_comb begin
    nxt_val = '0;
    if (nxt_idx != 5'd0) begin
      if (wr_en && rd == nxt_idx) nxt_val = write_data;
      else                        nxt_val = regs_q[nxt_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = STREAM;
          idx_d   = 5'd0;
          data_d  = '0;
        end
      end
      STREAM: begin
        if (dump_ready) begin
          if (idx_q == 5'd31) begin
            state_d = DONE;
          end else begin
            idx_d  = nxt_idx;
            data_d = nxt_val;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = (state_q == STREAM);
  assign dump_busy  = (state_q != IDLE);
  assign dump_done  = (state_q == DONE);
  assign dump_index = idx_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_reg_file.sv
// Randomized bench for reg_file: a bypassing and a non-bypassing instance share
// stimulus and are compared every cycle against an array-based model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic        we, start, ready;
  logic [31:0] wd;

  logic signed [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        vld, busy, done, nb_vld, nb_busy, nb_done;
  logic [4:0]  idx, nb_idx;
  logic [31:0] ddata, nb_ddata;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .read_data1(rd1), .read_data2(rd2), .RegWrite(we), .rd(rd),
    .write_data(wd), .dump_start(start), .dump_valid(vld),
    .dump_ready(ready), .dump_index(idx), .dump_data(ddata),
    .dump_busy(busy), .dump_done(done)
  );

  reg_file #(.DATA_W(32), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .read_data1(nb_rd1), .read_data2(nb_rd2), .RegWrite(we), .rd(rd),
    .write_data(wd), .dump_start(start), .dump_valid(nb_vld),
    .dump_ready(ready), .dump_index(nb_idx), .dump_data(nb_ddata),
    .dump_busy(nb_busy), .dump_done(nb_done)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  // Reference model: architectural registers plus dump progress
  logic [31:0] mdl [32];
  bit          m_dump, m_done;
  int          m_idx;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] rs, input bit byp);
    if (rs == 5'd0) return 32'd0;
    if (byp && we && rd == rs) return wd;
    return mdl[rs];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    m_dump = 0; m_done = 0; m_idx = 0; m_data = 32'd0;
  endtask

  // Check outputs mid-cycle, then advance the model on the rising edge.
  task automatic step();
    logic [31:0] old [32];
    @(negedge clk);
    chk("rd1",      rd1,    exp_rd(rs1, 1));
    chk("rd2",      rd2,    exp_rd(rs2, 1));
    chk("nb_rd1",   nb_rd1, exp_rd(rs1, 0));
    chk("nb_rd2",   nb_rd2, exp_rd(rs2, 0));
    chk("valid",    {31'd0, vld},  {31'd0, m_dump});
    chk("busy",     {31'd0, busy}, {31'd0, m_dump || m_done});
    chk("done",     {31'd0, done}, {31'd0, m_done});
    chk("index",    {27'd0, idx},  m_idx);
    chk("data",     ddata,  m_data);
    chk("nb_valid", {31'd0, nb_vld}, {31'd0, m_dump});
    chk("nb_index", {27'd0, nb_idx}, m_idx);
    chk("nb_data",  nb_ddata, m_data);
    if (done) n_done++;
    @(posedge clk);
    if (reset) begin
      mdl_reset();
    end else begin
      old = mdl;
      if (we && rd != 5'd0) mdl[rd] = wd;
      if (m_done) begin
        m_done = 0;
      end else if (!m_dump) begin
        if (start) begin m_dump = 1; m_idx = 0; m_data = 32'd0; end
      end else if (ready) begin
        if (m_idx == 31) begin
          m_dump = 0; m_done = 1;
        end else begin
          m_idx++;
          m_data = (we && rd == m_idx[4:0]) ? wd : old[m_idx];
        end
      end
    end
    #1;
  endtask

  task automatic idle_in();
    reset = 0; we = 0; rd = 0; wd = 0; rs1 = 0; rs2 = 0; start = 0; ready = 0;
  endtask

  initial begin
    idle_in();
    reset = 1;
    @(posedge clk); #1;
    mdl_reset();
    step();
    reset = 0;
    rs1 = 5'd3; rs2 = 5'd31;
    step();

    // Write/read and x0 discard
    we = 1; rd = 5; wd = 32'hDEADBEEF; step();
    we = 1; rd = 0; wd = 32'h1234; rs1 = 5; rs2 = 0;
    #1 chk("x5_read", rd1, 32'hDEADBEEF);
    chk("x0_read", rd2, 32'd0);
    step();
    we = 0; rs1 = 0; rs2 = 0; step();

    // Same-cycle forwarding on both ports
    we = 1; rd = 7; wd = 32'h11; step();
    we = 1; rd = 7; wd = 32'hFFFFFFF9; rs1 = 7; rs2 = 7;
    #1 chk("byp_rd1", rd1, 32'hFFFFFFF9);
    chk("byp_rd2", rd2, 32'hFFFFFFF9);
    chk("nobyp_rd1", nb_rd1, 32'h11);
    chk("nobyp_rd2", nb_rd2, 32'h11);
    step();
    idle_in();

    // Full dump of xi = i*3
    for (int i = 1; i < 32; i++) begin we = 1; rd = i[4:0]; wd = i * 3; step(); end
    idle_in();
    n_done = 0;
    start = 1; step(); start = 0; ready = 1;
    for (int b = 0; b < 32; b++) begin
      #1 chk("full_idx", {27'd0, idx}, b);
      chk("full_data", ddata, b * 3);
      step();
    end
    chk("full_done", {31'd0, done}, 32'd1);
    step(); step();
    chk("done_cnt", n_done, 1);

    // Backpressure with a write to the held index during the stall
    idle_in(); start = 1; step(); start = 0;
    for (int c = 0; c < 140 && (m_dump || m_done); c++) begin
      ready = (c % 4 == 0) || (c % 4 == 3);
      we = (c % 4 == 1); rd = idx; wd = $urandom; rs1 = idx;
      step();
    end
    chk("bp_finished", {31'd0, m_dump}, 32'd0);
    idle_in(); step();

    // Reset mid-dump at index 12
    n_done = 0;
    for (int i = 1; i < 32; i++) begin we = 1; rd = i[4:0]; wd = $urandom; step(); end
    idle_in(); start = 1; step(); start = 0; ready = 1;
    for (int c = 0; c < 40 && m_idx != 12; c++) step();
    chk("at_12", {27'd0, idx}, 32'd12);
    reset = 1; step(); reset = 0; ready = 0;
    for (int r = 1; r < 32; r += 2) begin rs1 = r[4:0]; rs2 = r[4:0] + 5'd1; step(); end
    chk("no_done_after_rst", n_done, 0);
    idle_in();

    // dump_start ignored while streaming; restart the cycle after DONE
    start = 1; step(); start = 0; ready = 1;
    step(); step(); start = 1; step(); start = 0;
    for (int c = 0; c < 60 && !m_done; c++) step();
    chk("reached_done", {31'd0, m_done}, 32'd1);
    step();
    start = 1; step(); start = 0; ready = 0;
    #1 chk("restart_valid", {31'd0, vld}, 32'd1);
    chk("restart_idx", {27'd0, idx}, 32'd0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      we    = $urandom_range(0, 1);
      rd    = $urandom_range(0, 31);
      wd    = $urandom;
      rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      start = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
